// File: rtl/gowin_div_u24_by_u12.sv
// gowin_div_u24_by_u12: sequential radix-2 restoring unsigned divider, one quotient bit per enabled cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   ce           clock enable; low freezes every register including done
//   start        request, accepted when ce=1 and busy=0
//   dividend     DW_N-bit numerator, captured on the accepted start edge
//   divisor      DW_D-bit denominator, captured on the accepted start edge
//   busy         iteration in progress
//   done         one-enabled-cycle pulse; results valid from this cycle on
//   quotient     DW_N-bit result, held until the next done
//   remainder    DW_D-bit result, held until the next done
//   div_by_zero  set with a result produced from a zero divisor
//
// Optional build macro GOWIN_DIV_ROUND_EN: round the quotient to nearest
// (half up, saturating); the remainder stays truncated.
module gowin_div_u24_by_u12 #(
    parameter int DW_N = 24,
    parameter int DW_D = 12
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ce,
    input  logic            start,
    input  logic [DW_N-1:0] dividend,
    input  logic [DW_D-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [DW_N-1:0] quotient,
    output logic [DW_D-1:0] remainder,
    output logic            div_by_zero
);
    localparam int CW = $clog2(DW_N + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [DW_N-1:0] q_r, q_n, q_step, quo_n;
    logic [DW_D-1:0] r_r, r_n, r_step, d_r, d_n, rem_n;
    logic [DW_D:0] t;
    logic [CW-1:0] cnt, cnt_n;
    logic ge, done_n, dbz_n;
    // The partial remainder is always below the divisor, so it is kept DW_D
    // wide; the trial value t carries the one extra bit.
    always_comb begin
        t = {r_r, q_r[DW_N-1]};
        ge = t >= {1'b0, d_r};
        r_step = ge ? DW_D'(t - {1'b0, d_r}) : t[DW_D-1:0];
        q_step = {q_r[DW_N-2:0], ge};
    end
    always_comb begin
        state_n = state;
        q_n = q_r;
        r_n = r_r;
        d_n = d_r;
        cnt_n = cnt;
        quo_n = quotient;
        rem_n = remainder;
        dbz_n = div_by_zero;
        done_n = 1'b0;
        if (state == IDLE) begin
            if (start && divisor == '0) begin
                quo_n = '1;
                rem_n = dividend[DW_D-1:0];
                dbz_n = 1'b1;
                done_n = 1'b1;
            end else if (start) begin
                q_n = dividend;
                r_n = '0;
                d_n = divisor;
                cnt_n = CW'(DW_N);
                state_n = RUN;
            end
        end else begin
            q_n = q_step;
            r_n = r_step;
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1)) begin
`ifdef GOWIN_DIV_ROUND_EN
                quo_n = ({r_step, 1'b0} >= {1'b0, d_r}) && !(&q_step) ?
                        q_step + {{(DW_N-1){1'b0}}, 1'b1} : q_step;
`else
                quo_n = q_step;
`endif
                rem_n = r_step;
                dbz_n = 1'b0;
                done_n = 1'b1;
                state_n = IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            q_r <= '0;
            r_r <= '0;
            d_r <= '0;
            cnt <= '0;
            quotient <= '0;
            remainder <= '0;
            div_by_zero <= 1'b0;
            done <= 1'b0;
        end else if (ce) begin
            state <= state_n;
            q_r <= q_n;
            r_r <= r_n;
            d_r <= d_n;
            cnt <= cnt_n;
            quotient <= quo_n;
            remainder <= rem_n;
            div_by_zero <= dbz_n;
            done <= done_n;
        end
    end
    assign busy = state == RUN;
endmodule

// File: tb/tb_gowin_div_u24_by_u12.sv
// tb_gowin_div_u24_by_u12: randomized self-checking bench against an arithmetic reference divider.
module tb_gowin_div_u24_by_u12;
    logic clk = 0, reset_n = 0, ce = 1, start = 0;
    logic [23:0] dividend = 0;
    logic [11:0] divisor = 0;
    logic busy, done, div_by_zero;
    logic [23:0] quotient;
    logic [11:0] remainder;
    int total = 0, bad = 0;

    gowin_div_u24_by_u12 dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .start(start),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Expected result and latency (edges after the accepted start edge until done is seen).
    function automatic void model(input logic [23:0] a, input logic [11:0] b,
                                  output logic [23:0] q, output logic [11:0] r,
                                  output logic z, output int lat);
        if (b == 0) begin
            q = 24'hFFFFFF; r = a[11:0]; z = 1; lat = 0;
        end else begin
            q = a / b; r = 12'(a % b); z = 0; lat = 24;
`ifdef GOWIN_DIV_ROUND_EN
            if (2 * int'(r) >= int'(b) && q != 24'hFFFFFF) q = q + 1;
`endif
        end
    endfunction

    task automatic launch(input logic [23:0] a, input logic [11:0] b);
        @(negedge clk);
        dividend = a; divisor = b; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        total++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 39'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h z=%b want all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_basic;
        logic [23:0] ta [3] = '{24'd1000, 24'hFFFFFF, 24'd5};
        logic [11:0] tb [3] = '{12'd7, 12'hFFF, 12'd9};
        logic [23:0] eq; logic [11:0] er; logic ez; int el, lat;
        for (int i = 0; i < 3; i++) begin
            model(ta[i], tb[i], eq, er, ez, el);
            launch(ta[i], tb[i]);
            wait_done(lat);
            total++;
            if (lat !== el) begin
                bad++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, el);
            end
            total++;
            if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
                bad++;
                $display("FAIL basic_result[%0d]: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                         i, quotient, remainder, div_by_zero, eq, er, ez);
            end
        end
`ifndef GOWIN_DIV_ROUND_EN
        total++;
        if (quotient !== 24'd0 || remainder !== 12'd5) begin
            bad++; $display("FAIL small_over_large: got q=%0d r=%0d want q=0 r=5", quotient, remainder);
        end
`endif
    endtask

    task automatic test_div_zero;
        logic [23:0] eq; logic [11:0] er; logic ez; int el, lat;
        launch(24'h123456, 12'd0);
        wait_done(lat);
        total++;
        if (lat !== 0) begin
            bad++; $display("FAIL dbz_latency: got %0d want 0", lat);
        end
        total++;
        if ({quotient, remainder, div_by_zero} !== {24'hFFFFFF, 12'h456, 1'b1}) begin
            bad++;
            $display("FAIL dbz_result: got q=%h r=%h z=%b want q=ffffff r=456 z=1",
                     quotient, remainder, div_by_zero);
        end
        ce = 0;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL ce_freezes_done: got done=%b want 1", done);
        end
        ce = 1;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || quotient !== 24'hFFFFFF) begin
            bad++; $display("FAIL done_clears: got done=%b q=%h want done=0 q=ffffff", done, quotient);
        end
        model(24'd10, 12'd3, eq, er, ez, el);
        launch(24'd10, 12'd3);
        wait_done(lat);
        total++;
        if (lat !== el || {quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
            bad++;
            $display("FAIL after_dbz: got lat=%0d q=%0d r=%0d z=%b want lat=%0d q=%0d r=%0d z=%b",
                     lat, quotient, remainder, div_by_zero, el, eq, er, ez);
        end
    endtask

    task automatic test_random;
        logic [23:0] a, eq; logic [11:0] b, er; logic ez; int el, lat;
        for (int i = 0; i < 24; i++) begin
            a = 24'($urandom);
            b = (i % 6 == 0) ? 12'd0 : (i % 3 == 1) ? 12'($urandom_range(1, 15)) : 12'($urandom_range(1, 4095));
            model(a, b, eq, er, ez, el);
            launch(a, b);
            wait_done(lat);
            total++;
            if (lat !== el || {quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
                bad++;
                $display("FAIL random[%0d] %h/%h: got lat=%0d q=%h r=%h z=%b want lat=%0d q=%h r=%h z=%b",
                         i, a, b, lat, quotient, remainder, div_by_zero, el, eq, er, ez);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy_ignore;
        logic [23:0] eq; logic [11:0] er; logic ez; int el, lat, extra;
        model(24'd777777, 12'd123, eq, er, ez, el);
        launch(24'd777777, 12'd123);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL busy_high: got busy=%b want 1", busy);
        end
        dividend = 24'd50; divisor = 12'd0; start = 1;
        @(posedge clk); #1;
        start = 0;
        wait_done(lat);
        total++;
        if (lat + 6 !== el || {quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
            bad++;
            $display("FAIL busy_ignore: got lat=%0d q=%h r=%h z=%b want lat=%0d q=%h r=%h z=%b",
                     lat + 6, quotient, remainder, div_by_zero, el, eq, er, ez);
        end
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++; $display("FAIL not_queued: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] qa, eq; logic [11:0] ra, er; logic ez; int el, lat;
        logic held;
        model(24'd654321, 12'd77, qa, ra, ez, el);
        launch(24'd654321, 12'd77);
        wait_done(lat);
        total++;
        if ({quotient, remainder} !== {qa, ra}) begin
            bad++; $display("FAIL b2b_first: got q=%h r=%h want q=%h r=%h", quotient, remainder, qa, ra);
        end
        model(24'd999999, 12'd1000, eq, er, ez, el);
        launch(24'd999999, 12'd1000);
        lat = 0; held = 1;
        while (done !== 1'b1 && lat < 60) begin
            if (quotient !== qa || remainder !== ra) held = 0;
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (held !== 1'b1) begin
            bad++; $display("FAIL b2b_hold: got held=%b want 1", held);
        end
        total++;
        if (lat !== el || {quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h",
                     lat, quotient, remainder, el, eq, er);
        end
    endtask

    task automatic test_stall;
        logic [23:0] eq; logic [11:0] er; logic ez; int el, lat;
        logic busy_in_stall = 0;
        model(24'd4000000, 12'd999, eq, er, ez, el);
        launch(24'd4000000, 12'd999);
        lat = 0;
        while (done !== 1'b1 && lat < 80) begin
            ce = (lat >= 8 && lat < 13) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            lat++;
            if (lat == 11) busy_in_stall = busy;
        end
        ce = 1;
        total++;
        if (busy_in_stall !== 1'b1) begin
            bad++; $display("FAIL stall_busy: got busy=%b want 1", busy_in_stall);
        end
        total++;
        if (lat !== el + 5 || {quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
            bad++;
            $display("FAIL stall: got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h",
                     lat, quotient, remainder, el + 5, eq, er);
        end
    endtask

    task automatic test_reset_mid;
        logic [23:0] eq; logic [11:0] er; logic ez; int el, lat, seen;
        launch(24'd123456, 12'd321);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 0;
        #1;
        total++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 39'd0) begin
            bad++;
            $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h z=%b want all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
        end
        model(24'd8388607, 12'd2047, eq, er, ez, el);
        launch(24'd8388607, 12'd2047);
        wait_done(lat);
        total++;
        if (lat !== el || {quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
            bad++;
            $display("FAIL after_reset: got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h",
                     lat, quotient, remainder, el, eq, er);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_div_zero();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
